// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the next-PC sequencer: FSM encoding,
// next-PC source selector, default vectors and the PC increment.
package pc_sequencer_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    MDU_STALL = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_EXC,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_HOLD,
    SRC_SEQ
  } pc_src_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
  localparam logic [31:0] PC_INCR          = 32'd4;

  function automatic logic is_redirect(input pc_src_e src);
    return (src == SRC_EXC) || (src == SRC_BRANCH) || (src == SRC_JUMP);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Front-end control bundle between the sequencer and the pipeline
// (hazard unit, EX branch resolution, PC and IF/ID registers).
interface pc_sequencer_if;

  logic [31:0] pc_cur;
  logic        stall_req;
  logic        mdu_start;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exc_req;
  logic [31:0] PC_in;
  logic        PCWrite;
  logic        if_id_write;
  logic        if_id_flush;
  logic        mdu_busy;

  modport master (
    input  pc_cur, stall_req, mdu_start, branch_taken, branch_target,
           jump, jump_target, exc_req,
    output PC_in, PCWrite, if_id_write, if_id_flush, mdu_busy
  );

  modport slave (
    output pc_cur, stall_req, mdu_start, branch_taken, branch_target,
           jump, jump_target, exc_req,
    input  PC_in, PCWrite, if_id_write, if_id_flush, mdu_busy
  );

endinterface

// File: rtl/pc_sel_mux.sv
// Priority select of the next PC and its write enable:
// reset > exception > branch > jump > hold > sequential.
module pc_sel_mux
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic        in_reset,
  input  logic        exc_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        hold,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_write,
  output pc_src_e     src
);

  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    src      = SRC_SEQ;
    pc_next  = pc_cur + PC_INCR;
    pc_write = 1'b1;
    if (in_reset) begin
      src      = SRC_RESET;
      pc_next  = RESET_VECTOR;
      pc_write = 1'b0;
    end else if (exc_req) begin
      src     = SRC_EXC;
      pc_next = EXC_VECTOR;
    end else if (branch_taken) begin
      // The EX-stage branch is older than the ID-stage jump, so it wins.
      src     = SRC_BRANCH;
      pc_next = branch_target;
    end else if (jump) begin
      src     = SRC_JUMP;
      pc_next = jump_target;
    end else if (hold) begin
      src      = SRC_HOLD;
      pc_next  = pc_cur;
      pc_write = 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: drives the PC register and IF/ID controls, owns the
// multi-cycle MDU stall FSM and the post-redirect flush stretch counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          MDU_CYCLES   = 4,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             RST,
  pc_sequencer_if.master  bus
);

  localparam logic [3:0] MDU_LOAD   = 4'(MDU_CYCLES - 1);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_e      state;
  logic [3:0]  mdu_cnt;
  logic [1:0]  flush_cnt;
  logic        hold;
  logic        redirect;
  logic [31:0] pc_next;
  logic        pc_write;
  pc_src_e     src;

  assign hold = bus.stall_req || (state == MDU_STALL) || bus.mdu_start;

  pc_sel_mux #(
    .RESET_VECTOR (RESET_VECTOR),
    .EXC_VECTOR   (EXC_VECTOR)
  ) u_sel (
    .in_reset      (!RST),
    .exc_req       (bus.exc_req),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .hold          (hold),
    .pc_cur        (bus.pc_cur),
    .pc_next       (pc_next),
    .pc_write      (pc_write),
    .src           (src)
  );

  assign redirect        = is_redirect(src);
  assign bus.PC_in       = pc_next;
  assign bus.PCWrite     = pc_write;
  assign bus.if_id_write = redirect || (src == SRC_SEQ);
  assign bus.if_id_flush = !RST || redirect || (flush_cnt != 2'd0);
  assign bus.mdu_busy    = RST && (state == MDU_STALL);

  // The mdu_start cycle is itself the first held cycle, so MDU_STALL lasts
  // MDU_CYCLES-1 cycles: leave on the edge where the counter would reach 0.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!RST) begin
      state     <= RUN;
      mdu_cnt   <= 4'd0;
      flush_cnt <= 2'd0;
    end else begin
      if (redirect) begin
        flush_cnt <= FLUSH_LOAD;
      end else if (flush_cnt != 2'd0) begin
        flush_cnt <= flush_cnt - 2'd1;
      end

      if (bus.exc_req) begin
        state   <= RUN;
        mdu_cnt <= 4'd0;
      end else if (state == MDU_STALL) begin
        if (mdu_cnt <= 4'd1) begin
          state   <= RUN;
          mdu_cnt <= 4'd0;
        end else begin
          mdu_cnt <= mdu_cnt - 4'd1;
        end
      end else if (bus.mdu_start && !bus.branch_taken && !bus.jump &&
                   (MDU_CYCLES > 1)) begin
        state   <= MDU_STALL;
        mdu_cnt <= MDU_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: a driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_pc_sequencer;

  typedef struct {
    string       name;
    logic [31:0] pc_in;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        mdu_busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total  = 0;
  int   passed = 0;
  exp_t exp_q[$];

  pc_sequencer_if bus();

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (32'h8000_0180),
    .MDU_CYCLES   (4),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Drive one cycle of inputs just after the edge and queue the expectation.
  task automatic step(input string name, input logic r, input logic [31:0] pc,
                      input logic stall, input logic mdu, input logic br,
                      input logic [31:0] bt, input logic j, input logic [31:0] jt,
                      input logic exc, input logic [31:0] e_pc, input logic e_pcw,
                      input logic e_ifw, input logic e_fl, input logic e_busy);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.pc_cur        = pc;
    bus.stall_req     = stall;
    bus.mdu_start     = mdu;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = j;
    bus.jump_target   = jt;
    bus.exc_req       = exc;
    e.name = name; e.pc_in = e_pc; e.pc_write = e_pcw;
    e.if_id_write = e_ifw; e.if_id_flush = e_fl; e.mdu_busy = e_busy;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string name, input logic [31:0] pc, input logic [31:0] e_pc,
                      input logic e_pcw, input logic e_ifw, input logic e_fl, input logic e_busy);
    step(name, 1'b1, pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
         e_pc, e_pcw, e_ifw, e_fl, e_busy);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".PC_in"},       bus.PC_in,               e.pc_in);
        check({e.name, ".PCWrite"},     32'(bus.PCWrite),     32'(e.pc_write));
        check({e.name, ".if_id_write"}, 32'(bus.if_id_write), 32'(e.if_id_write));
        check({e.name, ".if_id_flush"}, 32'(bus.if_id_flush), 32'(e.if_id_flush));
        check({e.name, ".mdu_busy"},    32'(bus.mdu_busy),    32'(e.mdu_busy));
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    bus.pc_cur = '0; bus.stall_req = 1'b0; bus.mdu_start = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = '0; bus.jump = 1'b0;
    bus.jump_target = '0; bus.exc_req = 1'b0;

    // Reset then sequential fetch
    step("rst0", 1'b0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
    step("rst1", 1'b0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
    idle("seq4",  32'h0, 32'h4, 1, 1, 0, 0);
    idle("seq8",  32'h4, 32'h8, 1, 1, 0, 0);
    idle("seq12", 32'h8, 32'hC, 1, 1, 0, 0);

    // Load-use hold
    step("lu_hold", 1'b1, 32'h40, 1, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0, 0);
    idle("lu_next", 32'h40, 32'h44, 1, 1, 0, 0);

    // MDU stall, with stall_req on the start cycle and a repeated start ignored
    step("mdu_h1", 1'b1, 32'h100, 1, 1, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0);
    idle("mdu_h2", 32'h100, 32'h100, 0, 0, 0, 1);
    step("mdu_h3", 1'b1, 32'h100, 0, 1, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 1);
    idle("mdu_h4", 32'h100, 32'h100, 0, 0, 0, 1);
    idle("mdu_end", 32'h100, 32'h104, 1, 1, 0, 0);

    // Branch beats jump, flush stretched to two cycles
    step("br_jmp", 1'b1, 32'h104, 0, 0, 1, 32'h200, 1, 32'h300, 0, 32'h200, 1, 1, 1, 0);
    idle("br_fl2", 32'h200, 32'h204, 1, 1, 1, 0);
    idle("br_fl0", 32'h204, 32'h208, 1, 1, 0, 0);

    // Exception in the second held cycle of an MDU stall
    step("exc_h1", 1'b1, 32'h208, 0, 1, 0, 0, 0, 0, 0, 32'h208, 0, 0, 0, 0);
    step("exc_go", 1'b1, 32'h208, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0180, 1, 1, 1, 1);
    idle("exc_n1", 32'h8000_0180, 32'h8000_0184, 1, 1, 1, 0);
    idle("exc_n2", 32'h8000_0184, 32'h8000_0188, 1, 1, 0, 0);

    // Jump during MDU stall overrides one cycle; stall keeps counting
    step("mj_h1", 1'b1, 32'h300, 0, 1, 0, 0, 0, 0, 0, 32'h300, 0, 0, 0, 0);
    step("mj_jmp", 1'b1, 32'h300, 0, 0, 0, 0, 1, 32'h400, 0, 32'h400, 1, 1, 1, 1);
    idle("mj_h3", 32'h400, 32'h400, 0, 0, 1, 1);
    idle("mj_h4", 32'h400, 32'h400, 0, 0, 0, 1);
    idle("mj_end", 32'h400, 32'h404, 1, 1, 0, 0);

    // Wrap-around of the sequential increment
    idle("wrap", 32'hFFFF_FFFC, 32'h0, 1, 1, 0, 0);

    // Reset in the middle of an MDU stall
    step("rs_h1", 1'b1, 32'h0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    idle("rs_h2", 32'h0, 32'h0, 0, 0, 0, 1);
    step("rs_rst", 1'b0, 32'h50, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
    idle("rs_seq4", 32'h0, 32'h4, 1, 1, 0, 0);
    idle("rs_seq8", 32'h4, 32'h8, 1, 1, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
